// File: rtl/issue_stage_pkg.sv
// Shared definitions for the issue stage: entry field offsets, queue/register-file sizing,
// queue-entry and EXE-bundle layouts, and the oldest-first select helpers.
package issue_stage_pkg;

    localparam int ENTRIES = 8;
    localparam int NPHYS   = 64;
    localparam int TAG_W   = 6;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CNT_W   = IDX_W + 1;
    localparam int INFO_W  = 170;

    // bit offsets inside rename_issueinfo
    localparam int F_SRC_S   = 0;
    localparam int F_SRC_T   = 6;
    localparam int F_DEST    = 12;
    localparam int F_PC      = 18;
    localparam int F_INSTR   = 50;
    localparam int F_HILO    = 82;
    localparam int F_ALUC    = 84;
    localparam int F_SYS     = 90;
    localparam int F_SZEXT   = 91;
    localparam int F_JREG    = 92;
    localparam int F_REGWR   = 93;
    localparam int F_ALUSRC  = 94;
    localparam int F_MEMWR   = 95;
    localparam int F_MEMRD   = 96;
    localparam int F_BRANCH  = 97;
    localparam int F_JUMP    = 98;
    localparam int F_REGDEST = 99;
    localparam int F_LINK    = 100;
    localparam int F_ALTPC   = 101;
    localparam int F_SHAMT   = 133;
    localparam int F_IMM     = 138;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [INFO_W-1:0] info_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] num;
        info_t       info;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  c;
        logic        rdy_s;
        logic        rdy_t;
        logic        rdy_d;
    } iq_entry_t;

    typedef struct packed {
        tag_t        regwr_tag;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  shamt;
        logic [5:0]  alu_con;
        logic [1:0]  hilo;
        logic        regwr;
        logic        memwr;
        logic        memrd;
        logic        branch;
        logic        jump;
        logic        jreg;
        logic        regdest;
        logic        link;
        logic        sys;
        logic        alusrc;
        logic [31:0] alt_pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] mem_wdata;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  c;
        logic [31:0] num;
    } exe_out_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic [31:0]      num;
    } sel_node_t;

    function automatic tag_t src_s(input info_t i);
        return i[F_SRC_S +: TAG_W];
    endfunction

    function automatic tag_t src_t(input info_t i);
        return i[F_SRC_T +: TAG_W];
    endfunction

    function automatic tag_t dst_d(input info_t i);
        return i[F_DEST +: TAG_W];
    endfunction

    function automatic logic tag_hit(input tag_t tag, input logic v0, input tag_t m0,
                                     input logic v1, input tag_t m1);
        return (v0 && (m0 == tag)) || (v1 && (m1 == tag));
    endfunction

    // left operand always covers lower slots, so "<=" resolves ties to the lowest slot
    function automatic sel_node_t pick_older(input sel_node_t l, input sel_node_t r);
        return (l.vld && (!r.vld || (l.num <= r.num))) ? l : r;
    endfunction

    function automatic sel_node_t select_oldest(input sel_node_t [ENTRIES-1:0] leaf);
        sel_node_t tree [2*ENTRIES-1];
        for (int i = 0; i < ENTRIES; i++) tree[ENTRIES-1+i] = leaf[i];
        for (int k = ENTRIES-2; k >= 0; k--) tree[k] = pick_older(tree[2*k+1], tree[2*k+2]);
        return tree[0];
    endfunction

endpackage

// File: rtl/issue_stage_if.sv
// Rename-to-issue request bundle and the registered issue-to-EXE bundle.
interface issue_stage_if;
    import issue_stage_pkg::*;

    logic                rename_enque;
    logic [31:0]         rename_instr_num;
    logic [INFO_W-1:0]   rename_issueinfo;
    logic [NPHYS-1:0]    busy;
    logic [4:0]          rename_A;
    logic [4:0]          rename_B;
    logic [4:0]          rename_C;
    logic                halt_rename;

    logic [TAG_W-1:0]    RegWr_exe;
    logic [31:0]         instr_exe;
    logic [31:0]         instr_pc_exe;
    logic [4:0]          shamt_exe;
    logic [5:0]          ALU_con_exe;
    logic [1:0]          hilo_exe;
    logic                RegWr_flag_exe;
    logic                MemWr_exe;
    logic                MemRd_exe;
    logic                branch_exe;
    logic                jump_exe;
    logic                jumpReg_exe;
    logic                regDest_exe;
    logic                link_exe;
    logic                sys_exe;
    logic                ALUSrc_exe;
    logic [31:0]         alt_PC_exe;
    logic [31:0]         operandA1_exe;
    logic [31:0]         operandB1_exe;
    logic [31:0]         MemWriteData_exe;
    logic [4:0]          A_exe;
    logic [4:0]          B_exe;
    logic [4:0]          C_exe;
    logic [31:0]         instr_num_exe;

    modport master (
        output rename_enque, rename_instr_num, rename_issueinfo, busy,
               rename_A, rename_B, rename_C,
        input  halt_rename,
               RegWr_exe, instr_exe, instr_pc_exe, shamt_exe, ALU_con_exe, hilo_exe,
               RegWr_flag_exe, MemWr_exe, MemRd_exe, branch_exe, jump_exe, jumpReg_exe,
               regDest_exe, link_exe, sys_exe, ALUSrc_exe, alt_PC_exe, operandA1_exe,
               operandB1_exe, MemWriteData_exe, A_exe, B_exe, C_exe, instr_num_exe
    );

    modport slave (
        input  rename_enque, rename_instr_num, rename_issueinfo, busy,
               rename_A, rename_B, rename_C,
        output halt_rename,
               RegWr_exe, instr_exe, instr_pc_exe, shamt_exe, ALU_con_exe, hilo_exe,
               RegWr_flag_exe, MemWr_exe, MemRd_exe, branch_exe, jump_exe, jumpReg_exe,
               regDest_exe, link_exe, sys_exe, ALUSrc_exe, alt_PC_exe, operandA1_exe,
               operandB1_exe, MemWriteData_exe, A_exe, B_exe, C_exe, instr_num_exe
    );

endinterface

// File: rtl/issue_stage_phys_reg_file.sv
// 64x32 physical register file: two write ports (port 2 wins), three combinational reads.
// Reads bypass same-cycle writes; tag 0 is hardwired to zero.
module phys_reg_file
    import issue_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        we1,
    input  tag_t        waddr1,
    input  logic [31:0] wdata1,
    input  logic        we2,
    input  tag_t        waddr2,
    input  logic [31:0] wdata2,
    input  tag_t        raddr_a,
    input  tag_t        raddr_b,
    input  tag_t        raddr_c,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic [31:0] rdata_c
);

    logic [31:0] regs [NPHYS];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
        end else begin
            if (we1 && (waddr1 != '0)) regs[waddr1] <= wdata1;
            if (we2 && (waddr2 != '0)) regs[waddr2] <= wdata2;
        end
    end

    function automatic logic [31:0] rd(input tag_t a);
        if (a == '0)               return '0;
        else if (we2 && waddr2 == a) return wdata2;
        else if (we1 && waddr1 == a) return wdata1;
        else                        return regs[a];
    endfunction

    assign rdata_a = rd(raddr_a);
    assign rdata_b = rd(raddr_b);
    assign rdata_c = rd(raddr_c);

endmodule

// File: rtl/issue_stage.sv
// 8-entry out-of-order issue queue with broadcast wakeup and oldest-ready select.
// Insert->issue 2 edges; broadcast->issue 1 edge. halt_rename asserts while full.
module issue_stage
    import issue_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic        exe_broadcast,
    input  tag_t        exe_broadcast_map,
    input  logic [31:0] exe_broadcast_val,
    input  logic        mem_broadcast,
    input  tag_t        mem_broadcast_map,
    input  logic [31:0] mem_broadcast_val,
    input  logic [31:0] rob_instr_num,
    issue_stage_if.slave ifc
);

    iq_entry_t                 iq_q [ENTRIES];
    iq_entry_t                 new_e;
    exe_out_t                  out_q, out_d;
    sel_node_t [ENTRIES-1:0]   leaves;
    sel_node_t                 sel;
    logic [ENTRIES-1:0]        hit_s, hit_t, hit_d;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          ins_idx;
    logic                      full, do_insert, do_issue;
    iq_entry_t                 sel_e;
    logic [31:0]               rd_s, rd_t, rd_d;
    logic                      unused_ok;

    function automatic logic bc_hit(input tag_t tag);
        return tag_hit(tag, exe_broadcast, exe_broadcast_map, mem_broadcast, mem_broadcast_map);
    endfunction

    always_comb begin
        cnt     = '0;
        ins_idx = '0;
        for (int i = ENTRIES-1; i >= 0; i--) begin
            hit_s[i]      = bc_hit(src_s(iq_q[i].info));
            hit_t[i]      = bc_hit(src_t(iq_q[i].info));
            hit_d[i]      = bc_hit(dst_d(iq_q[i].info));
            // readiness includes this cycle's broadcasts so a woken entry issues next edge
            leaves[i].vld = iq_q[i].vld && (iq_q[i].rdy_s || hit_s[i])
                            && (iq_q[i].rdy_t || hit_t[i]) && (iq_q[i].rdy_d || hit_d[i]);
            leaves[i].idx = IDX_W'(i);
            leaves[i].num = iq_q[i].num;
            if (!iq_q[i].vld) ins_idx = IDX_W'(i);
            cnt = cnt + CNT_W'(iq_q[i].vld);
        end
    end

    assign sel       = select_oldest(leaves);
    assign full      = (cnt == CNT_W'(ENTRIES));
    assign do_insert = ifc.rename_enque && !full && !FLUSH;
    assign do_issue  = sel.vld && !STALL && !FLUSH;
    assign sel_e     = iq_q[sel.idx];

    always_comb begin
        new_e       = '0;
        new_e.vld   = 1'b1;
        new_e.num   = ifc.rename_instr_num;
        new_e.info  = ifc.rename_issueinfo;
        new_e.a     = ifc.rename_A;
        new_e.b     = ifc.rename_B;
        new_e.c     = ifc.rename_C;
        new_e.rdy_s = (ifc.rename_A == '0) || !ifc.busy[src_s(ifc.rename_issueinfo)]
                      || bc_hit(src_s(ifc.rename_issueinfo));
        new_e.rdy_t = (ifc.rename_B == '0) || !ifc.busy[src_t(ifc.rename_issueinfo)]
                      || bc_hit(src_t(ifc.rename_issueinfo));
        new_e.rdy_d = (ifc.rename_C == '0) || !ifc.busy[dst_d(ifc.rename_issueinfo)]
                      || bc_hit(dst_d(ifc.rename_issueinfo));
    end

    phys_reg_file u_prf (
        .CLK     (CLK),
        .RESET   (RESET),
        .we1     (exe_broadcast),
        .waddr1  (exe_broadcast_map),
        .wdata1  (exe_broadcast_val),
        .we2     (mem_broadcast),
        .waddr2  (mem_broadcast_map),
        .wdata2  (mem_broadcast_val),
        .raddr_a (src_s(sel_e.info)),
        .raddr_b (src_t(sel_e.info)),
        .raddr_c (dst_d(sel_e.info)),
        .rdata_a (rd_s),
        .rdata_b (rd_t),
        .rdata_c (rd_d)
    );

    always_comb begin
        out_d = '0;
        if (do_issue) begin
            out_d.regwr_tag = dst_d(sel_e.info);
            out_d.instr     = sel_e.info[F_INSTR +: 32];
            out_d.pc        = sel_e.info[F_PC +: 32];
            out_d.shamt     = sel_e.info[F_SHAMT +: 5];
            out_d.alu_con   = sel_e.info[F_ALUC +: 6];
            out_d.hilo      = sel_e.info[F_HILO +: 2];
            out_d.regwr     = sel_e.info[F_REGWR];
            out_d.memwr     = sel_e.info[F_MEMWR];
            out_d.memrd     = sel_e.info[F_MEMRD];
            out_d.branch    = sel_e.info[F_BRANCH];
            out_d.jump      = sel_e.info[F_JUMP];
            out_d.jreg      = sel_e.info[F_JREG];
            out_d.regdest   = sel_e.info[F_REGDEST];
            out_d.link      = sel_e.info[F_LINK];
            out_d.sys       = sel_e.info[F_SYS];
            out_d.alusrc    = sel_e.info[F_ALUSRC];
            out_d.alt_pc    = sel_e.info[F_ALTPC +: 32];
            out_d.op_a      = rd_s;
            out_d.op_b      = (sel_e.b == '0) ? sel_e.info[F_IMM +: 32] : rd_t;
            out_d.mem_wdata = rd_d;
            out_d.a         = sel_e.a;
            out_d.b         = sel_e.b;
            out_d.c         = sel_e.c;
            out_d.num       = sel_e.num;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < ENTRIES; i++) iq_q[i] <= '0;
            out_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (FLUSH) begin
                    iq_q[i].vld <= 1'b0;
                end else if (do_insert && (ins_idx == IDX_W'(i))) begin
                    iq_q[i] <= new_e;
                end else if (do_issue && (sel.idx == IDX_W'(i))) begin
                    iq_q[i].vld <= 1'b0;
                end else begin
                    iq_q[i].rdy_s <= iq_q[i].rdy_s | hit_s[i];
                    iq_q[i].rdy_t <= iq_q[i].rdy_t | hit_t[i];
                    iq_q[i].rdy_d <= iq_q[i].rdy_d | hit_d[i];
                end
            end
            out_q <= out_d;
        end
    end

    assign ifc.halt_rename      = full;
    assign ifc.RegWr_exe        = out_q.regwr_tag;
    assign ifc.instr_exe        = out_q.instr;
    assign ifc.instr_pc_exe     = out_q.pc;
    assign ifc.shamt_exe        = out_q.shamt;
    assign ifc.ALU_con_exe      = out_q.alu_con;
    assign ifc.hilo_exe         = out_q.hilo;
    assign ifc.RegWr_flag_exe   = out_q.regwr;
    assign ifc.MemWr_exe        = out_q.memwr;
    assign ifc.MemRd_exe        = out_q.memrd;
    assign ifc.branch_exe       = out_q.branch;
    assign ifc.jump_exe         = out_q.jump;
    assign ifc.jumpReg_exe      = out_q.jreg;
    assign ifc.regDest_exe      = out_q.regdest;
    assign ifc.link_exe         = out_q.link;
    assign ifc.sys_exe          = out_q.sys;
    assign ifc.ALUSrc_exe       = out_q.alusrc;
    assign ifc.alt_PC_exe       = out_q.alt_pc;
    assign ifc.operandA1_exe    = out_q.op_a;
    assign ifc.operandB1_exe    = out_q.op_b;
    assign ifc.MemWriteData_exe = out_q.mem_wdata;
    assign ifc.A_exe            = out_q.a;
    assign ifc.B_exe            = out_q.b;
    assign ifc.C_exe            = out_q.c;
    assign ifc.instr_num_exe    = out_q.num;

    // sign/zero-extend select and the ROB pointer have no consumer at this stage
    assign unused_ok = ^{rob_instr_num, sel_e.info[F_SZEXT]};

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: hand-computed expectations for insert, wakeup, select order,
// full/drop, FLUSH, STALL, bypass priority and mid-run reset.
module tb_issue_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic        exe_broadcast = 1'b0;
    logic [5:0]  exe_broadcast_map = '0;
    logic [31:0] exe_broadcast_val = '0;
    logic        mem_broadcast = 1'b0;
    logic [5:0]  mem_broadcast_map = '0;
    logic [31:0] mem_broadcast_val = '0;
    logic [31:0] rob_instr_num = '0;

    int checks = 0;
    int failures = 0;

    issue_stage_if ifc();

    issue_stage u_dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .FLUSH             (FLUSH),
        .exe_broadcast     (exe_broadcast),
        .exe_broadcast_map (exe_broadcast_map),
        .exe_broadcast_val (exe_broadcast_val),
        .mem_broadcast     (mem_broadcast),
        .mem_broadcast_map (mem_broadcast_map),
        .mem_broadcast_val (mem_broadcast_val),
        .rob_instr_num     (rob_instr_num),
        .ifc               (ifc)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [169:0] mk_info(input logic [5:0] s, input logic [5:0] t,
                                             input logic [5:0] d, input logic [31:0] pc,
                                             input logic [31:0] imm);
        logic [169:0] v;
        v          = '0;
        v[5:0]     = s;
        v[11:6]    = t;
        v[17:12]   = d;
        v[49:18]   = pc;
        v[81:50]   = 32'h2000_0000 | pc;
        v[93]      = 1'b1;
        v[169:138] = imm;
        return v;
    endfunction

    // present one insert for a single cycle
    task automatic put(input logic [31:0] num, input logic [5:0] s, input logic [5:0] t,
                       input logic [5:0] d, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input logic [31:0] imm);
        ifc.rename_enque     = 1'b1;
        ifc.rename_instr_num = num;
        ifc.rename_issueinfo = mk_info(s, t, d, 32'h400 + num, imm);
        ifc.rename_A         = a;
        ifc.rename_B         = b;
        ifc.rename_C         = c;
        tick();
        ifc.rename_enque     = 1'b0;
    endtask

    initial begin
        ifc.rename_enque     = 1'b0;
        ifc.rename_instr_num = '0;
        ifc.rename_issueinfo = '0;
        ifc.busy             = '0;
        ifc.rename_A         = '0;
        ifc.rename_B         = '0;
        ifc.rename_C         = '0;

        tick();
        tick();
        chk("rst_halt", ifc.halt_rename, 0);
        chk("rst_regwr", ifc.RegWr_exe, 0);
        chk("rst_opa", ifc.operandA1_exe, 0);
        RESET = 1'b1;

        // phys[3]=7 through the mem port, then a ready entry reading it with an immediate
        mem_broadcast = 1'b1; mem_broadcast_map = 6'd3; mem_broadcast_val = 32'd7;
        tick();
        mem_broadcast = 1'b0;
        put(1, 6'd3, 6'd0, 6'd9, 5'd1, 5'd0, 5'd2, 32'd5);
        chk("ins_latency", ifc.RegWr_exe, 0);
        tick();
        chk("t1_opa", ifc.operandA1_exe, 7);
        chk("t1_opb", ifc.operandB1_exe, 5);
        chk("t1_regwr", ifc.RegWr_exe, 9);
        chk("t1_flag", ifc.RegWr_flag_exe, 1);
        chk("t1_pc", ifc.instr_pc_exe, 32'h401);
        chk("t1_a", ifc.A_exe, 1);
        chk("t1_num", ifc.instr_num_exe, 1);
        tick();
        chk("t1_nop", ifc.RegWr_exe, 0);

        // wakeup with same-cycle bypass
        ifc.busy[10] = 1'b1;
        put(2, 6'd10, 6'd0, 6'd11, 5'd3, 5'd0, 5'd4, 32'd0);
        tick();
        chk("t2_wait", ifc.RegWr_exe, 0);
        mem_broadcast = 1'b1; mem_broadcast_map = 6'd10; mem_broadcast_val = 32'h55;
        tick();
        mem_broadcast = 1'b0;
        ifc.busy[10] = 1'b0;
        chk("t2_opa", ifc.operandA1_exe, 32'h55);
        chk("t2_regwr", ifc.RegWr_exe, 11);

        // oldest first regardless of slot
        STALL = 1'b1;
        put(5, 6'd0, 6'd0, 6'd20, 5'd0, 5'd0, 5'd0, 32'd0);
        put(3, 6'd0, 6'd0, 6'd21, 5'd0, 5'd0, 5'd0, 32'd0);
        STALL = 1'b0;
        tick();
        chk("t3_first", ifc.instr_num_exe, 3);
        chk("t3_first_d", ifc.RegWr_exe, 21);
        tick();
        chk("t3_second", ifc.instr_num_exe, 5);

        // fill on blocked tag 12, drop 9th, then release
        ifc.busy[12] = 1'b1;
        for (int i = 0; i < 8; i++)
            put(32'(10 + i), 6'd12, 6'd0, 6'(30 + i), 5'd5, 5'd0, 5'd0, 32'd0);
        chk("t4_full", ifc.halt_rename, 1);
        put(9, 6'd0, 6'd0, 6'd40, 5'd0, 5'd0, 5'd0, 32'd0);
        chk("t4_halt_hold", ifc.halt_rename, 1);
        chk("t4_nop", ifc.RegWr_exe, 0);
        exe_broadcast = 1'b1; exe_broadcast_map = 6'd12; exe_broadcast_val = 32'h1234;
        tick();
        exe_broadcast = 1'b0;
        ifc.busy[12] = 1'b0;
        chk("t4_oldest", ifc.instr_num_exe, 10);
        chk("t4_oldest_opa", ifc.operandA1_exe, 32'h1234);
        chk("t4_halt_drop", ifc.halt_rename, 0);
        tick();
        chk("t4_next", ifc.instr_num_exe, 11);
        chk("t4_next_opa", ifc.operandA1_exe, 32'h1234);
        tick();
        tick();
        chk("t4_fourth", ifc.instr_num_exe, 13);

        // flush with 4 entries left; concurrent insert dropped
        FLUSH = 1'b1;
        put(50, 6'd0, 6'd0, 6'd49, 5'd0, 5'd0, 5'd0, 32'd0);
        FLUSH = 1'b0;
        chk("fl_nop", ifc.RegWr_exe, 0);
        chk("fl_num", ifc.instr_num_exe, 0);
        tick();
        chk("fl_empty", ifc.RegWr_exe, 0);
        chk("fl_halt", ifc.halt_rename, 0);

        // stall three cycles with a ready entry
        STALL = 1'b1;
        put(60, 6'd0, 6'd0, 6'd45, 5'd0, 5'd0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_nop", ifc.RegWr_exe, 0);
        end
        STALL = 1'b0;
        tick();
        chk("stall_issue", ifc.RegWr_exe, 45);

        // MEM beats EXE on equal tag, both in bypass and in the register file
        ifc.busy[13] = 1'b1;
        put(80, 6'd13, 6'd0, 6'd47, 5'd6, 5'd0, 5'd0, 32'd0);
        tick();
        chk("t6_wait", ifc.RegWr_exe, 0);
        exe_broadcast = 1'b1; exe_broadcast_map = 6'd13; exe_broadcast_val = 32'd1;
        mem_broadcast = 1'b1; mem_broadcast_map = 6'd13; mem_broadcast_val = 32'd2;
        tick();
        exe_broadcast = 1'b0;
        mem_broadcast = 1'b0;
        ifc.busy[13] = 1'b0;
        chk("t6_bypass", ifc.operandA1_exe, 2);
        put(81, 6'd13, 6'd3, 6'd48, 5'd6, 5'd7, 5'd0, 32'h99);
        tick();
        chk("t6_rf", ifc.operandA1_exe, 2);
        chk("t6_opb_reg", ifc.operandB1_exe, 7);

        // reset mid-run clears outputs, queue and register file
        STALL = 1'b1;
        put(90, 6'd0, 6'd0, 6'd50, 5'd0, 5'd0, 5'd0, 32'd0);
        put(91, 6'd0, 6'd0, 6'd51, 5'd0, 5'd0, 5'd0, 32'd0);
        STALL = 1'b0;
        tick();
        chk("rr_pre", ifc.RegWr_exe, 50);
        #2 RESET = 1'b0;
        #1;
        chk("rr_regwr", ifc.RegWr_exe, 0);
        chk("rr_num", ifc.instr_num_exe, 0);
        chk("rr_halt", ifc.halt_rename, 0);
        RESET = 1'b1;
        tick();
        chk("rr_empty", ifc.RegWr_exe, 0);
        put(92, 6'd3, 6'd0, 6'd52, 5'd1, 5'd0, 5'd0, 32'd0);
        tick();
        chk("rr_rf_zero", ifc.operandA1_exe, 0);
        chk("rr_issue", ifc.RegWr_exe, 52);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
